collision_ctrl: RTL
===================

Name: collision_ctrl

Overview:
- Game-state controller directly downstream of the plane, lava and mountain object modules.
- Checks each frame's object positions for overlap with the plane and tracks lives and survival time.
- Drives the game_over signal that freezes those object modules.
- Runs on the system clock. Collisions are evaluated only on a one-cycle frame_tick pulse, which the top level asserts while object positions are stable.

Parameters:
PLANE_X, 60, fixed left x of plane box
PLANE_W, 40, plane box width
PLANE_H, 20, plane box height
LAVA_Y, 240, fixed top y of lava box
LAVA_W, 20, lava box width
LAVA_H, 20, lava box height
MTN_W, 40, mountain box width
GROUND_Y, 440, bottom y of every mountain box (exclusive)
START_LIVES, 3, lives loaded at round start (1..7)
INVULN_FRAMES, 8, frame ticks of invulnerability after a non-fatal hit

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle start/restart pulse
frame_tick  in  1  one-cycle pulse; positions valid this cycle
plane_y  in  10  plane top y
lava_x  in  10  lava left x
mountain1_x, mountain1_y, mountain2_x, mountain2_y  in  10 each  mountain left x / top y
game_over  out  1  1 = objects frozen (IDLE or OVER)
state  out  2  00 IDLE, 01 PLAYING, 10 HIT, 11 OVER
lives  out  3  remaining lives
hit_pulse  out  1  one-cycle pulse on a counted hit
hit_mask  out  3  {lava, mountain2, mountain1} sources of last counted hit
new_round  out  1  one-cycle pulse on entering PLAYING from IDLE/OVER; top uses it to reset objects
survive_cnt  out  16  frame ticks survived this round
best_cnt  out  16  best survive_cnt since reset

Behaviour:
- Reset (async, resetn=0) values:
  - state=IDLE, game_over=1, lives=START_LIVES.
  - hit_pulse=0, hit_mask=0, new_round=0.
  - survive_cnt=0, best_cnt=0.
- Boxes are half-open: [lo, hi).
  - Plane: [PLANE_X, PLANE_X+PLANE_W) x [plane_y, plane_y+PLANE_H).
  - Lava: [lava_x, lava_x+LAVA_W) x [LAVA_Y, LAVA_Y+LAVA_H).
  - Mountain n: [mn_x, mn_x+MTN_W) x [mn_y, GROUND_Y).
- Overlap test: a_lo < b_hi AND b_lo < a_hi on both axes. Touching edges is not a hit.
- All sums are computed at 11 bits, so there is no wrap.
- Overlap is combinational. Its result is registered on a clock edge where frame_tick=1; all effects appear the cycle after frame_tick (latency 1).
- IDLE:
  - game_over=1.
  - start -> PLAYING: lives=START_LIVES, survive_cnt=0, new_round=1 for one cycle, hit_mask=0.
  - frame_tick is ignored.
- PLAYING:
  - game_over=0.
  - On each frame_tick, survive_cnt increments, saturating at 16'hFFFF.
  - If any overlap exists on that tick:
    - hit_pulse=1, hit_mask = all overlapping sources, lives decrements by 1.
    - If the new lives is 0 -> OVER; otherwise -> HIT with the invulnerability counter cleared.
  - Several simultaneous overlaps cost exactly one life.
- HIT:
  - game_over=0; survive_cnt keeps counting.
  - Overlaps are ignored: no pulse, hit_mask holds its value.
  - The counter increments per frame_tick. On the tick that makes it equal INVULN_FRAMES -> PLAYING.
- OVER:
  - game_over=1.
  - On entry, best_cnt <= survive_cnt if survive_cnt > best_cnt.
  - start -> PLAYING, same actions as from IDLE.
- Simultaneous events and mid-operation reset:
  - start in PLAYING or HIT is ignored.
  - start together with frame_tick in IDLE/OVER: start wins, and no collision or count happens that cycle.
  - resetn mid-round returns to the reset values immediately; best_cnt is cleared.
- Only resetn clears best_cnt.

Optional Feature:
- Macro: COLLISION_LIVES_EN.
- When defined: the multi-life behaviour above applies (START_LIVES, HIT state, invulnerability).
- When undefined:
  - lives is fixed at 1.
  - Any counted hit goes PLAYING -> OVER directly.
  - The HIT state is unreachable and the invulnerability counter is not synthesised.
  - START_LIVES and INVULN_FRAMES are ignored.

Test Plan:
- Clear play, no hit: reset; start; plane_y=50, lava_x=550, m1=(300,150), m2=(500,150); 5 frame_ticks -> state=01, survive_cnt=5, lives=3, hit_pulse never 1.
- Mountain hit: in PLAYING, m1=(80,150), plane_y=140, frame_tick -> next cycle hit_pulse=1, hit_mask=001, lives=2, state=10.
- Edge touch and invulnerability:
  - plane_y=130, m1=(80,150) -> no hit.
  - After a hit, 7 ticks with overlap -> no further pulse, state=10.
  - 8th tick -> state=01.
- Lava and mountain together: lava_x=90, plane_y=230, m2=(70,200) on one tick -> hit_mask=110, lives decrements by exactly 1.
- Game over and best score:
  - Lose all 3 lives with survive_cnt=20 -> state=11, game_over=1, best_cnt=20.
  - start -> new_round pulse, survive_cnt=0, lives=3.
  - A round ending at 12 leaves best_cnt=20.
- Macro off: one overlap tick -> state=11 directly, lives=0; start together with frame_tick in OVER -> PLAYING with survive_cnt=0.

Source files
------------

// File: rtl/collision_ctrl.sv
// Game-state controller: plane/lava/mountain overlap checks on frame_tick, lives, survival score.
// Optional multi-life mode (HIT state + invulnerability) is enabled by defining COLLISION_LIVES_EN.
module collision_ctrl #(
  parameter int PLANE_X  = 60,
  parameter int PLANE_W  = 40,
  parameter int PLANE_H  = 20,
  parameter int LAVA_Y   = 240,
  parameter int LAVA_W   = 20,
  parameter int LAVA_H   = 20,
  parameter int MTN_W    = 40,
  parameter int GROUND_Y = 440
`ifdef COLLISION_LIVES_EN
  ,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 8
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [9:0]  plane_y,
  input  logic [9:0]  lava_x,
  input  logic [9:0]  mountain1_x,
  input  logic [9:0]  mountain1_y,
  input  logic [9:0]  mountain2_x,
  input  logic [9:0]  mountain2_y,
  output logic        game_over,
  output logic [1:0]  state,
  output logic [2:0]  lives,
  output logic        hit_pulse,
  output logic [2:0]  hit_mask,
  output logic        new_round,
  output logic [15:0] survive_cnt,
  output logic [15:0] best_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PLAYING = 2'b01,
    ST_HIT     = 2'b10,
    ST_OVER    = 2'b11
  } state_e;

`ifdef COLLISION_LIVES_EN
  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
  localparam int         INV_W      = $clog2(INVULN_FRAMES + 1);
  logic [INV_W-1:0] inv_q, inv_d;
`else
  localparam logic [2:0] LIVES_INIT = 3'd1;
`endif

  state_e      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic        hit_pulse_q, hit_pulse_d;
  logic [2:0]  hit_mask_q, hit_mask_d;
  logic        new_round_q, new_round_d;
  logic [15:0] survive_q, survive_d, survive_inc;
  logic [15:0] best_q, best_d;

  // Half-open interval overlap; operands are 11 bits so the +width sums never wrap.
  function automatic logic ovl(input logic [10:0] a_lo, a_hi, b_lo, b_hi);
    return (a_lo < b_hi) && (b_lo < a_hi);
  endfunction

  logic [10:0] py_lo, py_hi, px_lo, px_hi;
  logic [10:0] lx_lo, m1x_lo, m1y_lo, m2x_lo, m2y_lo;
  logic        hit_lava, hit_m1, hit_m2;
  logic [2:0]  hits;

  assign py_lo  = {1'b0, plane_y};
  assign py_hi  = py_lo + 11'(PLANE_H);
  assign px_lo  = 11'(PLANE_X);
  assign px_hi  = 11'(PLANE_X + PLANE_W);
  assign lx_lo  = {1'b0, lava_x};
  assign m1x_lo = {1'b0, mountain1_x};
  assign m1y_lo = {1'b0, mountain1_y};
  assign m2x_lo = {1'b0, mountain2_x};
  assign m2y_lo = {1'b0, mountain2_y};

  assign hit_lava = ovl(px_lo, px_hi, lx_lo, lx_lo + 11'(LAVA_W)) &&
                    ovl(py_lo, py_hi, 11'(LAVA_Y), 11'(LAVA_Y + LAVA_H));
  assign hit_m1   = ovl(px_lo, px_hi, m1x_lo, m1x_lo + 11'(MTN_W)) &&
                    ovl(py_lo, py_hi, m1y_lo, 11'(GROUND_Y));
  assign hit_m2   = ovl(px_lo, px_hi, m2x_lo, m2x_lo + 11'(MTN_W)) &&
                    ovl(py_lo, py_hi, m2y_lo, 11'(GROUND_Y));
  assign hits     = {hit_lava, hit_m2, hit_m1};

  assign survive_inc = (survive_q == 16'hFFFF) ? survive_q : survive_q + 16'd1;

  // NOTE: async reset clears every register; none of them is a memory array.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_INIT;
      hit_pulse_q <= 1'b0;
      hit_mask_q  <= 3'b000;
      new_round_q <= 1'b0;
      survive_q   <= 16'd0;
      best_q      <= 16'd0;
`ifdef COLLISION_LIVES_EN
      inv_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q     <= state_d;
      lives_q     <= lives_d;
      hit_pulse_q <= hit_pulse_d;
      hit_mask_q  <= hit_mask_d;
      new_round_q <= new_round_d;
      survive_q   <= survive_d;
      best_q      <= best_d;
`ifdef COLLISION_LIVES_EN
      inv_q       <= inv_d;
`endif
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    state_d     = state_q;
    lives_d     = lives_q;
    hit_pulse_d = 1'b0;
    hit_mask_d  = hit_mask_q;
    new_round_d = 1'b0;
    survive_d   = survive_q;
    best_d      = best_q;
`ifdef COLLISION_LIVES_EN
    inv_d       = inv_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        // start has priority; a coincident frame_tick is dropped.
        if (start) begin
          state_d     = ST_PLAYING;
          lives_d     = LIVES_INIT;
          survive_d   = 16'd0;
          new_round_d = 1'b1;
          hit_mask_d  = 3'b000;
        end
      end
      ST_PLAYING: begin
        if (frame_tick) begin
          survive_d = survive_inc;
          if (|hits) begin
            hit_pulse_d = 1'b1;
            hit_mask_d  = hits;
            lives_d     = lives_q - 3'd1;
`ifdef COLLISION_LIVES_EN
            if (lives_d == 3'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_HIT;
              inv_d   = '0;
            end
`else
            state_d = ST_OVER;
`endif
          end
        end
      end
      ST_HIT: begin
`ifdef COLLISION_LIVES_EN
        if (frame_tick) begin
          survive_d = survive_inc;
          inv_d     = inv_q + 1'b1;
          if (inv_d == INV_W'(INVULN_FRAMES)) state_d = ST_PLAYING;
        end
`endif
      end
      default: ;
    endcase
    // Best score is latched on the transition into OVER using the final tick's count.
    if (state_d == ST_OVER && state_q != ST_OVER && survive_d > best_q) best_d = survive_d;
  end

  always_comb begin
    game_over = (state_q == ST_IDLE) || (state_q == ST_OVER);
  end

  assign state       = state_q;
  assign lives       = lives_q;
  assign hit_pulse   = hit_pulse_q;
  assign hit_mask    = hit_mask_q;
  assign new_round   = new_round_q;
  assign survive_cnt = survive_q;
  assign best_cnt    = best_q;

endmodule
